mem_arbiter2: RTL and testbench

Two-master arbiter sharing one picorv32-style native memory port between two requesters, e.g. two picorv32 cores, or one core plus a DMA/debug master, in place-and-route test designs. It selects a requester with round-robin priority and forwards the request to the shared slave port through registers. It routes the response back to the granted master only, and aborts any transfer the slave never acknowledges with a bounded timeout.

---
 rtl/mem_arbiter2.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter2.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master round-robin arbiter in front of one picorv32-style
// native memory port. The winning request is registered onto the slave port.
// The response goes back to the granted master only. A slave that never
// answers is cut off after TIMEOUT cycles, and the abort is flagged.
module mem_arbiter2 #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A TIMEOUT of zero disables the abort path entirely.
  localparam logic        TO_EN     = (TIMEOUT != 32'd0);
  localparam logic [15:0] TCNT_LAST = (TIMEOUT != 32'd0) ? 16'(TIMEOUT - 32'd1) : 16'd0;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        s_valid_q, s_valid_d;
  logic        s_instr_q, s_instr_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        timeout_err_q, timeout_err_d;

  logic        win;
  logic        abort;

  // The limit is only meaningful while a transfer is granted.
  assign abort = TO_EN && (tcnt_q == TCNT_LAST);

  // Pick the requester that would win if we are in IDLE: prio breaks ties.
  always_comb begin
    if (m0_valid && m1_valid) begin
      win = prio_q;
    end else if (m1_valid) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  // State and datapath registers; reset beats every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      tcnt_q        <= 16'd0;
      s_valid_q     <= 1'b0;
      s_instr_q     <= 1'b0;
      s_addr_q      <= 32'd0;
      s_wdata_q     <= 32'd0;
      s_wstrb_q     <= 4'd0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= 32'd0;
      m1_rdata_q    <= 32'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      tcnt_q        <= tcnt_d;
      s_valid_q     <= s_valid_d;
      s_instr_q     <= s_instr_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wstrb_q     <= s_wstrb_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state: grant on a request, leave GRANT on completion or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = win ? ST_GRANT1 : ST_GRANT0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (s_ready || abort) begin
          state_d = ST_RESP;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner's request, route the reply, pulse ready/abort.
  always_comb begin
    prio_d        = prio_q;
    owner_d       = owner_q;
    tcnt_d        = tcnt_q;
    s_valid_d     = s_valid_q;
    s_instr_d     = s_instr_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wstrb_d     = s_wstrb_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          owner_d   = win;
          tcnt_d    = 16'd0;
          s_valid_d = 1'b1;
          if (win) begin
            s_instr_d = m1_instr;
            s_addr_d  = m1_addr;
            s_wdata_d = m1_wdata;
            s_wstrb_d = m1_wstrb;
          end else begin
            s_instr_d = m0_instr;
            s_addr_d  = m0_addr;
            s_wdata_d = m0_wdata;
            s_wstrb_d = m0_wstrb;
          end
        end else begin
          s_valid_d = 1'b0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        // A late s_ready on the limit cycle still counts as a completion.
        if (s_ready) begin
          s_valid_d = 1'b0;
          prio_d    = ~owner_q;
          if (owner_q) begin
            m1_rdata_d = s_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = s_rdata;
            m0_ready_d = 1'b1;
          end
        end else if (abort) begin
          s_valid_d     = 1'b0;
          prio_d        = ~owner_q;
          timeout_err_d = 1'b1;
          if (owner_q) begin
            m1_rdata_d = 32'd0;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = 32'd0;
            m0_ready_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      ST_RESP: s_valid_d = 1'b0;
      default: s_valid_d = 1'b0;
    endcase
  end

  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2 (TIMEOUT=4). Stimulus pushes the expected
// completion of every transfer; a monitor pops and checks on each ready pulse.
module tb_mem_arbiter2;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  mem_arbiter2 #(.TIMEOUT(32'd4)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] rdata;
    logic        terr;
    int          nsv;
    int          gap;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;

  // slave model configuration: wait cycles (-1 = never answer), data key
  int          slv_wait = -1;
  int          slv_cnt = 0;
  logic [31:0] slv_key = 32'd0;
  logic        force_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle counter for spacing checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic m, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic instr, input logic [31:0] rdata,
                      input logic terr, input int nsv, input int gap);
    item_t e;
    e.m = m; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.instr = instr;
    e.rdata = rdata; e.terr = terr; e.nsv = nsv; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {28'd0, m0_ready, m1_ready, s_valid, timeout_err}, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_s_addr"}, s_addr, 32'd0);
    chk({tag, "_s_wdata"}, s_wdata, 32'd0);
    chk({tag, "_s_instr_wstrb"}, {27'd0, s_instr, s_wstrb}, 32'd0);
  endtask

  task automatic wait_ready(input int m, input int budget, output int lat);
    logic r;
    lat = 0;
    r = 1'b0;
    while (!r && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      r = (m == 1) ? m1_ready : m0_ready;
    end
    chk((m == 1) ? "wait_m1_ready" : "wait_m0_ready", {31'd0, r}, 32'd1);
  endtask

  // Slave: answers after slv_wait GRANT cycles, rdata = s_addr ^ slv_key.
  initial begin
    s_ready = 1'b0;
    s_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (s_valid && slv_wait >= 0 && slv_cnt == slv_wait) s_ready = 1'b1;
      else s_ready = force_rdy;
      s_rdata = s_addr ^ slv_key;
      if (s_valid) slv_cnt++;
      else slv_cnt = 0;
    end
  end

  // Monitor: pop and compare on every ready pulse; track slave-side request.
  initial begin
    item_t       e;
    int          sv_cnt;
    logic [31:0] sv_addr, sv_wdata;
    logic [4:0]  sv_ctl;
    logic [31:0] last_rd [2];
    int          last_cyc [2];
    sv_cnt = 0; sv_addr = 32'd0; sv_wdata = 32'd0; sv_ctl = 5'd0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    last_cyc[0] = 0; last_cyc[1] = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        sv_cnt = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
      end else begin
        if (m0_ready || m1_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("both_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
            chk("rsp_master", {31'd0, m1_ready}, {31'd0, e.m});
            chk("rsp_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            chk("rsp_timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
            chk("other_rdata_hold", e.m ? m0_rdata : m1_rdata, last_rd[e.m ? 0 : 1]);
            chk("s_valid_cycles", sv_cnt, e.nsv);
            chk("s_addr_fwd", sv_addr, e.addr);
            chk("s_wdata_fwd", sv_wdata, e.wdata);
            chk("s_instr_wstrb_fwd", {27'd0, sv_ctl}, {27'd0, e.instr, e.wstrb});
            if (e.gap != 0) chk("rr_spacing", cyc - last_cyc[e.m ? 1 : 0], e.gap);
            last_cyc[e.m ? 1 : 0] = cyc;
            last_rd[e.m ? 1 : 0] = e.rdata;
          end
          sv_cnt = 0;
        end else if (timeout_err) begin
          chk("orphan_timeout_err", {31'd0, timeout_err}, 32'd0);
        end
        if (s_valid) begin
          if (sv_cnt == 0) begin
            sv_addr = s_addr;
            sv_wdata = s_wdata;
            sv_ctl = {s_instr, s_wstrb};
          end else begin
            chk("s_addr_stable", s_addr, sv_addr);
            chk("s_wdata_stable", s_wdata, sv_wdata);
            chk("s_ctl_stable", {27'd0, s_instr, s_wstrb}, {27'd0, sv_ctl});
          end
          sv_cnt++;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int lat;
    reset = 1'b1;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // single read, 2 wait states
    slv_wait = 2; slv_key = 32'hDEADBFEF;
    push(1'b0, 32'h0000_0100, 32'd0, 4'd0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 0);
    m0_addr = 32'h0000_0100; m0_valid = 1'b1;
    wait_ready(0, 20, lat);
    chk("lat_read_2wait", lat, 32'd4);
    @(negedge clk); m0_valid = 1'b0;
    repeat (2) @(negedge clk);

    // write forwarding from m1
    slv_wait = 1; slv_key = 32'h1000_0000;
    push(1'b1, 32'h0000_2000, 32'h12345678, 4'b0101, 1'b0, 32'h1000_2000, 1'b0, 2, 0);
    m1_addr = 32'h0000_2000; m1_wdata = 32'h12345678; m1_wstrb = 4'b0101; m1_valid = 1'b1;
    wait_ready(1, 20, lat);
    chk("lat_write_1wait", lat, 32'd3);
    @(negedge clk); m1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // timeout on m0 with m1 pending; m1 then served normally
    slv_wait = -1; slv_key = 32'd0;
    push(1'b0, 32'h0000_0300, 32'd0, 4'd0, 1'b1, 32'd0, 1'b1, 4, 0);
    push(1'b1, 32'h0000_0400, 32'd0, 4'd0, 1'b0, 32'h0000_0400, 1'b0, 1, 0);
    m0_addr = 32'h0000_0300; m0_instr = 1'b1; m0_valid = 1'b1;
    m1_addr = 32'h0000_0400; m1_wdata = 32'd0; m1_wstrb = 4'd0; m1_valid = 1'b1;
    wait_ready(0, 20, lat);
    chk("lat_timeout", lat, 32'd5);
    @(negedge clk); m0_valid = 1'b0; m0_instr = 1'b0; slv_wait = 0;
    wait_ready(1, 20, lat);
    @(negedge clk); m1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // s_ready on the final timeout cycle completes normally
    slv_wait = 3; slv_key = 32'hFF00_0000;
    push(1'b1, 32'h0000_0500, 32'd0, 4'd0, 1'b0, 32'hFF00_0500, 1'b0, 4, 0);
    m1_addr = 32'h0000_0500; m1_valid = 1'b1;
    wait_ready(1, 20, lat);
    chk("lat_boundary", lat, 32'd5);
    @(negedge clk); m1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // contention from reset, zero-wait slave
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; slv_wait = 0; slv_key = 32'h00AB_0000;
    push(1'b0, 32'h0000_00A0, 32'd0, 4'd0, 1'b0, 32'h00AB_00A0, 1'b0, 1, 0);
    push(1'b1, 32'h0000_00B0, 32'd0, 4'd0, 1'b0, 32'h00AB_00B0, 1'b0, 1, 0);
    push(1'b0, 32'h0000_00A0, 32'd0, 4'd0, 1'b0, 32'h00AB_00A0, 1'b0, 1, 6);
    push(1'b1, 32'h0000_00B0, 32'd0, 4'd0, 1'b0, 32'h00AB_00B0, 1'b0, 1, 6);
    m0_addr = 32'h0000_00A0; m1_addr = 32'h0000_00B0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    wait_ready(0, 20, lat);
    chk("lat_zero_wait", lat, 32'd2);
    wait_ready(1, 20, lat);
    wait_ready(0, 20, lat);
    wait_ready(1, 20, lat);
    @(negedge clk); m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // reset during a GRANT1 wait state, then a stray s_ready
    slv_wait = -1; slv_key = 32'd0;
    m1_addr = 32'h0000_0600; m1_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("reset_mid_grant");
    @(negedge clk);
    reset = 1'b0; m1_valid = 1'b0; force_rdy = 1'b1;
    repeat (3) @(negedge clk);
    force_rdy = 1'b0;
    check_zero("after_reset");

    // prio back to 0: a tie goes to m0 first
    slv_wait = 0;
    push(1'b0, 32'h0000_0700, 32'd0, 4'd0, 1'b0, 32'h0000_0700, 1'b0, 1, 0);
    push(1'b1, 32'h0000_0710, 32'd0, 4'd0, 1'b0, 32'h0000_0710, 1'b0, 1, 0);
    m0_addr = 32'h0000_0700; m1_addr = 32'h0000_0710;
    m0_valid = 1'b1; m1_valid = 1'b1;
    wait_ready(0, 20, lat);
    chk("lat_after_reset_tie", lat, 32'd2);
    @(negedge clk); m0_valid = 1'b0;
    wait_ready(1, 20, lat);
    @(negedge clk); m1_valid = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
